prog_run_ctrl: RTL and testbench



---
 rtl/prog_run_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_prog_run_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl
// -------------
// Run controller for the single-cycle CPU datapath. It sequences one program
// execution:
//   IDLE -> ARM  : host asserts Start; the core is held in reset while the
//                  host loads operands into data memory.
//   ARM  -> INIT : Start is released; the program select is latched here.
//   INIT -> RUN  : one cycle that strobes the program start address into the PC.
//   RUN  -> DONE : the decoder flags Halt, or the cycle watchdog expires.
//   DONE -> ARM  : host asserts Start again for the next run.
//
// Ports
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous active-low reset
//   Start     in   host launch request (level)
//   ProgSel   in   program select, latched on ARM->INIT
//   Halt      in   decoder reports a halt instruction at the current PC
//   Stall     in   datapath stall request
//   CoreRst   out  hold register file / datapath in reset (ARM)
//   PcLoad    out  one-cycle PC load strobe (INIT)
//   PcInit    out  PC load value, zero outside INIT
//   PcEn      out  PC advance / writeback enable (RUN & ~Stall & ~Halt)
//   Ack       out  run complete (DONE)
//   Timeout   out  last run was ended by the watchdog
//   CycleCnt  out  RUN cycles of the last or current run
module prog_run_ctrl #(
  parameter int unsigned           PC_W       = 10,
  parameter int unsigned           CNT_W      = 16,
  parameter logic [CNT_W-1:0]      MAX_CYCLES = 16'd50000,
  parameter logic [PC_W-1:0]       PROG0_ADDR = 10'd0,
  parameter logic [PC_W-1:0]       PROG1_ADDR = 10'd128,
  parameter logic [PC_W-1:0]       PROG2_ADDR = 10'd256,
  parameter logic [PC_W-1:0]       PROG3_ADDR = 10'd384
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic             Stall,
  output logic             CoreRst,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcInit,
  output logic             PcEn,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_INIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // The watchdog fires while the counter still shows the last permitted RUN
  // cycle, so a run can never last more than MAX_CYCLES cycles.
  localparam logic [CNT_W-1:0] LIMIT_LAST = MAX_CYCLES - {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             core_rst_q;
  logic             pc_load_q;
  logic             ack_q;
  logic             run_q;

  // Start address lookup for a program select value.
  function automatic logic [PC_W-1:0] start_addr(input logic [1:0] sel);
    logic [PC_W-1:0] addr;
    case (sel)
      2'd0:    addr = PROG0_ADDR;
      2'd1:    addr = PROG1_ADDR;
      2'd2:    addr = PROG2_ADDR;
      2'd3:    addr = PROG3_ADDR;
      default: addr = PROG0_ADDR;
    endcase
    return addr;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Run sequencer: state, latched select, counter, watchdog flag and the
  // registered control outputs, which are all set for the state being entered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'd0;
      cnt_q      <= {CNT_W{1'b0}};
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b0;
      pc_load_q  <= 1'b0;
      ack_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q    <= ST_ARM;
            core_rst_q <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (Start) begin
            state_q    <= ST_ARM;
          end else begin
            // Host finished loading memory: latch the program and start fresh.
            state_q    <= ST_INIT;
            sel_q      <= ProgSel;
            core_rst_q <= 1'b0;
            pc_load_q  <= 1'b1;
            cnt_q      <= {CNT_W{1'b0}};
            timeout_q  <= 1'b0;
          end
        end
        ST_INIT: begin
          state_q   <= ST_RUN;
          pc_load_q <= 1'b0;
          run_q     <= 1'b1;
        end
        ST_RUN: begin
          if (Halt) begin
            // Halt has priority over the watchdog; the halt cycle is counted.
            state_q <= ST_DONE;
            run_q   <= 1'b0;
            ack_q   <= 1'b1;
            cnt_q   <= sat_inc(cnt_q);
          end else if (cnt_q == LIMIT_LAST) begin
            // Watchdog expiry: counter is left at the last permitted value.
            state_q   <= ST_DONE;
            run_q     <= 1'b0;
            ack_q     <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
            cnt_q   <= sat_inc(cnt_q);
          end
        end
        ST_DONE: begin
          if (Start) begin
            // Counter and Timeout keep the finished run's result until INIT.
            state_q    <= ST_ARM;
            ack_q      <= 1'b0;
            core_rst_q <= 1'b1;
          end else begin
            state_q    <= ST_DONE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          sel_q      <= 2'd0;
          cnt_q      <= {CNT_W{1'b0}};
          timeout_q  <= 1'b0;
          core_rst_q <= 1'b0;
          pc_load_q  <= 1'b0;
          ack_q      <= 1'b0;
          run_q      <= 1'b0;
        end
      endcase
    end
  end

  // PcInit is decoded from registered state only; it reads zero outside INIT.
  always_comb begin
    if (pc_load_q) begin
      PcInit = start_addr(sel_q);
    end else begin
      PcInit = {PC_W{1'b0}};
    end
  end

  // Stall and Halt gate the advance in the same cycle, so the halting
  // instruction never moves the PC.
  assign PcEn     = run_q & ~Stall & ~Halt;
  assign CoreRst  = core_rst_q;
  assign PcLoad   = pc_load_q;
  assign Ack      = ack_q;
  assign Timeout  = timeout_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl. Two instances share the stimulus: dut_a uses the
// default watchdog limit, dut_b a limit of 8 for the watchdog scenarios.
module tb_prog_run_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  ProgSel = 2'd0;
  logic        Halt = 1'b0;
  logic        Stall = 1'b0;

  logic        a_corerst, a_pcload, a_pcen, a_ack, a_timeout;
  logic [9:0]  a_pcinit;
  logic [15:0] a_cnt;
  logic        b_corerst, b_pcload, b_pcen, b_ack, b_timeout;
  logic [9:0]  b_pcinit;
  logic [15:0] b_cnt;

  prog_run_ctrl dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .Stall(Stall), .CoreRst(a_corerst), .PcLoad(a_pcload), .PcInit(a_pcinit),
    .PcEn(a_pcen), .Ack(a_ack), .Timeout(a_timeout), .CycleCnt(a_cnt)
  );

  prog_run_ctrl #(.MAX_CYCLES(16'd8)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .Stall(Stall), .CoreRst(b_corerst), .PcLoad(b_pcload), .PcInit(b_pcinit),
    .PcEn(b_pcen), .Ack(b_ack), .Timeout(b_timeout), .CycleCnt(b_cnt)
  );

  always #5 Clk = ~Clk;

  // Observation mux: obs_b selects which instance the checks look at.
  logic        obs_b = 1'b0;
  logic        o_corerst, o_pcload, o_pcen, o_ack, o_timeout;
  logic [9:0]  o_pcinit;
  logic [15:0] o_cnt;
  always_comb begin
    o_corerst = obs_b ? b_corerst : a_corerst;
    o_pcload  = obs_b ? b_pcload  : a_pcload;
    o_pcen    = obs_b ? b_pcen    : a_pcen;
    o_ack     = obs_b ? b_ack     : a_ack;
    o_timeout = obs_b ? b_timeout : a_timeout;
    o_pcinit  = obs_b ? b_pcinit  : a_pcinit;
    o_cnt     = obs_b ? b_cnt     : a_cnt;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        to;
    logic [15:0] cnt;
    int          adv;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_corerst"}, {31'd0, o_corerst}, 32'd0);
    check({tag, "_pcload"},  {31'd0, o_pcload},  32'd0);
    check({tag, "_pcinit"},  {22'd0, o_pcinit},  32'd0);
    check({tag, "_pcen"},    {31'd0, o_pcen},    32'd0);
    check({tag, "_ack"},     {31'd0, o_ack},     32'd0);
    check({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
    check({tag, "_cnt"},     {16'd0, o_cnt},     32'd0);
  endtask

  // Start held for 4 sampling edges -> 4 ARM cycles, then one INIT cycle.
  task automatic launch(input logic [1:0] sel, input logic [9:0] addr);
    @(negedge Clk);
    Start   = 1'b1;
    ProgSel = sel;
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      check("arm_corerst", {31'd0, o_corerst}, 32'd1);
      check("arm_pcload",  {31'd0, o_pcload},  32'd0);
      if (i == 4) Start = 1'b0;
    end
    @(negedge Clk);
    check("init_pcload",  {31'd0, o_pcload},  32'd1);
    check("init_pcinit",  {22'd0, o_pcinit},  {22'd0, addr});
    check("init_corerst", {31'd0, o_corerst}, 32'd0);
    check("init_cnt",     {16'd0, o_cnt},     32'd0);
    check("init_timeout", {31'd0, o_timeout}, 32'd0);
    check("init_pcen",    {31'd0, o_pcen},    32'd0);
    // Changing the select after the latch edge must not affect this run.
    ProgSel = ~sel;
  endtask

  // Drive RUN cycles (1-based k) until Ack, then compare against the scoreboard.
  task automatic run(input int halt_at, input int st_lo, input int st_hi,
                     input logic exp_to, input logic [15:0] exp_cnt, input int exp_adv);
    exp_t e;
    int   adv;
    int   k;
    bit   done;
    e.to = exp_to; e.cnt = exp_cnt; e.adv = exp_adv;
    sb.push_back(e);
    adv  = 0;
    k    = 0;
    done = 1'b0;
    while (!done && k < 100) begin
      @(negedge Clk);
      if (o_ack) begin
        done = 1'b1;
      end else begin
        k++;
        Halt  = (k == halt_at);
        Stall = (k >= st_lo) && (k <= st_hi);
        #1;
        check("run_pcen", {31'd0, o_pcen}, {31'd0, (!Halt && !Stall)});
        check("run_cnt",  {16'd0, o_cnt},  k - 1);
        if (o_pcen) adv++;
      end
    end
    Halt  = 1'b0;
    Stall = 1'b0;
    check("ack_seen", {31'd0, done}, 32'd1);
    e = sb.pop_front();
    check("done_timeout", {31'd0, o_timeout}, {31'd0, e.to});
    check("done_cnt",     {16'd0, o_cnt},     {16'd0, e.cnt});
    check("done_adv",     adv,                e.adv);
    check("done_pcen",    {31'd0, o_pcen},    32'd0);
    check("done_pcinit",  {22'd0, o_pcinit},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // 1: reset, then idle.
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check_all_zero("idle");
    end

    // 2: ProgSel=1 launch with a short run.
    launch(2'd1, 10'd128);
    run(5, 0, 0, 1'b0, 16'd5, 4);

    // 3: ProgSel=0, halt in RUN cycle 20.
    launch(2'd0, 10'd0);
    run(20, 0, 0, 1'b0, 16'd20, 19);

    // 4: stall in cycles 3-5, halt at 10.
    launch(2'd2, 10'd256);
    run(10, 3, 5, 1'b0, 16'd10, 6);

    // 5: watchdog with limit 8 on dut_b.
    obs_b = 1'b1;
    launch(2'd0, 10'd0);
    run(0, 0, 0, 1'b1, 16'd7, 8);
    // dut_a is still running; halt it so both sit in DONE.
    obs_b = 1'b0;
    @(negedge Clk);
    Halt = 1'b1;
    @(negedge Clk);
    Halt = 1'b0;
    check("a_ack_after_halt", {31'd0, a_ack}, 32'd1);
    obs_b = 1'b1;
    launch(2'd1, 10'd128);
    run(8, 0, 0, 1'b0, 16'd8, 7);
    obs_b = 1'b0;

    // 6: asynchronous reset mid-RUN, then a fresh ProgSel=3 run.
    launch(2'd2, 10'd256);
    repeat (4) @(negedge Clk);
    check("pre_reset_pcen", {31'd0, a_pcen}, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_all_zero("post_rst");
    launch(2'd3, 10'd384);
    run(4, 0, 0, 1'b0, 16'd4, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
